// File: rtl/wallace_mul16_seq.sv
// Sequential 16x16 multiplier built around one combinational 8x8 Wallace
// product unit. The four byte partial products go through the shared unit,
// one per cycle, and are summed into a 32-bit accumulator. Signed operands
// are handled as magnitudes, and the sign is applied to the final sum.

// 8x8 unsigned product: eight shifted AND rows reduced by 3:2 carry-save
// layers (8 -> 6 -> 4 -> 3 -> 2), then one carry-propagate add.
module wallace_8x8_product (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    logic [7:0][15:0] pp;
    logic [15:0] s1a, c1a, s1b, c1b;
    logic [15:0] s2a, c2a, s2b, c2b;
    logic [15:0] s3, c3, s4, c4;

    // Every row and every carry vector is no larger than the final product,
    // and the product fits in 16 bits. The carry shifts can therefore be
    // truncated to 16 bits without losing information.
    function automatic logic [15:0] sum3(input logic [15:0] u, v, w);
        return u ^ v ^ w;
    endfunction

    function automatic logic [15:0] car3(input logic [15:0] u, v, w);
        return ((u & v) | (u & w) | (v & w)) << 1;
    endfunction

    // Partial product rows: row i is x gated by y[i], shifted left by i.
    always_comb begin
        for (int i = 0; i < 8; i++)
            pp[i] = {8'b0, x & {8{y[i]}}} << i;
    end

    // Carry-save reduction tree.
    always_comb begin
        s1a = sum3(pp[0], pp[1], pp[2]);
        c1a = car3(pp[0], pp[1], pp[2]);
        s1b = sum3(pp[3], pp[4], pp[5]);
        c1b = car3(pp[3], pp[4], pp[5]);
        s2a = sum3(s1a, c1a, s1b);
        c2a = car3(s1a, c1a, s1b);
        s2b = sum3(c1b, pp[6], pp[7]);
        c2b = car3(c1b, pp[6], pp[7]);
        s3  = sum3(s2a, c2a, s2b);
        c3  = car3(s2a, c2a, s2b);
        s4  = sum3(s3, c3, c2b);
        c4  = car3(s3, c3, c2b);
        p   = s4 + c4;
    end
endmodule

module wallace_mul16_seq #(
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state, state_nxt;
    logic [1:0]  step;
    logic [31:0] acc, acc_next, res_fin;
    logic [15:0] ma, mb, abs_a, abs_b;
    logic        neg, sgn_mode, load;
    logic        ia, ib;
    logic [7:0]  mx, my;
    logic [15:0] p16;
    logic [4:0]  shamt;

    wallace_8x8_product u_w8 (
        .x (mx),
        .y (my),
        .p (p16)
    );

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and the handshake outputs decoded from state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: if (step == 2'd3) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes, byte selection and the accumulate / sign-fix datapath.
    // The 8x8 inputs follow ma/mb ungated, because they are only used in MUL.
    always_comb begin
        sgn_mode = SIGNED_EN && is_signed;
        abs_a    = a[15] ? (~a + 16'd1) : a;
        abs_b    = b[15] ? (~b + 16'd1) : b;
        ia       = step[0];
        ib       = step[1];
        mx       = ia ? ma[15:8] : ma[7:0];
        my       = ib ? mb[15:8] : mb[7:0];
        shamt    = {({1'b0, ia} + {1'b0, ib}), 3'b000};
        acc_next = acc + ({16'b0, p16} << shamt);
        res_fin  = neg ? (~acc_next + 32'd1) : acc_next;
    end

    // Operand capture, step counter, accumulator and result register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ma   <= '0;
            mb   <= '0;
            neg  <= 1'b0;
            step <= '0;
            acc  <= '0;
            z    <= '0;
        end else if (load) begin
            ma   <= sgn_mode ? abs_a : a;
            mb   <= sgn_mode ? abs_b : b;
            neg  <= sgn_mode && (a[15] ^ b[15]);
            step <= '0;
            acc  <= '0;
        end else if (state == MUL) begin
            acc  <= acc_next;
            step <= step + 2'd1;
            if (step == 2'd3) z <= res_fin;
        end
    end
endmodule

// File: tb/tb_wallace_mul16_seq.sv
// Bench for wallace_mul16_seq. A signed-enabled instance and an
// unsigned-only instance share the same stimulus. The results are compared
// with a plain-arithmetic multiply model.
module tb_wallace_mul16_seq;
    logic        clk, clrn, in_valid, out_ready, is_signed;
    logic [15:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [31:0] z;
    logic        u_in_ready, u_out_valid, u_busy;
    logic [31:0] u_z;
    int          n_chk = 0, n_fail = 0;

    wallace_mul16_seq #(.SIGNED_EN(1'b1)) dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .busy(busy));

    wallace_mul16_seq #(.SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(u_in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(u_out_valid),
        .out_ready(out_ready), .z(u_z), .busy(u_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_mul(input logic [15:0] x, y, input logic s);
        longint sx, sy, pr;
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        pr = sx * sy;
        return pr[31:0];
    endfunction

    // Runs one transaction with out_ready forced high once the result is
    // valid. Contains no comparisons; a timeout is reported through 'to'.
    task automatic run_op(input logic [15:0] xa, xb, input logic s,
                          output logic [31:0] zr, output logic [31:0] zur, output bit to);
        int n;
        to = 0;
        a = xa; b = xb; is_signed = s; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (n >= 20) to = 1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        if (n >= 20) to = 1;
        zr = z; zur = u_z;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; is_signed = 1'b0;
        #2;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_chk++; if (z !== 32'h0) begin n_fail++; $display("FAIL reset_z got %h want 0", z); end
        tick();
        clrn = 1'b1;
        tick();
    endtask

    task automatic test_unsigned();
        int first, nbusy;
        a = 16'hFFFF; b = 16'hFFFF; is_signed = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL uns_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        first = -1; nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) nbusy++;
            if (out_valid && first < 0) begin
                first = i;
                n_chk++; if (z !== 32'hFFFE0001) begin n_fail++; $display("FAIL uns_z got %h want fffe0001", z); end
            end
            tick();
        end
        n_chk++; if (first !== 4) begin n_fail++; $display("FAIL uns_latency got %0d want 4", first); end
        n_chk++; if (nbusy !== 5) begin n_fail++; $display("FAIL uns_busy_cycles got %0d want 5", nbusy); end
        out_ready = 1'b0;
    endtask

    task automatic test_signed();
        logic [15:0] ta [4] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
        logic [15:0] tb [4] = '{16'h8000, 16'h0002, 16'h8000, 16'h8000};
        logic [31:0] tz [4] = '{32'h40000000, 32'hFFFFFFFE, 32'hC0008000, 32'h00000000};
        logic [31:0] zr, zur;
        bit to;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], 1'b1, zr, zur, to);
            n_chk++; if (to) begin n_fail++; $display("FAIL sgn_timeout case %0d", i); end
            n_chk++; if (zr !== tz[i]) begin n_fail++; $display("FAIL sgn_z case %0d got %h want %h", i, zr, tz[i]); end
            if (i == 1) begin
                n_chk++; if (zur !== 32'h0001FFFE) begin n_fail++; $display("FAIL uns_only_z got %h want 0001fffe", zur); end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        a = 16'h1234; b = 16'h5678; is_signed = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        n_chk++; if (n >= 20) begin n_fail++; $display("FAIL bp_timeout got %0d cycles", n); end
        for (int i = 0; i < 10; i++) begin
            n_chk++; if (z !== 32'h06260060) begin n_fail++; $display("FAIL bp_z cycle %0d got %h want 06260060", i, z); end
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d got %b want 1", i, out_valid); end
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready cycle %0d got %b want 0", i, in_ready); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    endtask

    task automatic test_ignore_busy();
        int n;
        a = 16'd3; b = 16'd5; is_signed = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'd7; b = 16'd9;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ign_ready_mul got %b want 0", in_ready); end
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        n_chk++; if (z !== 32'd15) begin n_fail++; $display("FAIL ign_first_z got %0d want 15", z); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        n_chk++; if (z !== 32'd63) begin n_fail++; $display("FAIL ign_second_z got %0d want 63", z); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        logic [31:0] zr, zur;
        bit to;
        a = 16'h00FF; b = 16'h0100; is_signed = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        clrn = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
        n_chk++; if (z !== 32'h0) begin n_fail++; $display("FAIL rst_mid_z got %h want 0", z); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        #1;
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_result cycle %0d got %b want 0", i, out_valid); end
            tick();
        end
        run_op(16'd2, 16'd3, 1'b0, zr, zur, to);
        n_chk++; if (to || zr !== 32'd6) begin n_fail++; $display("FAIL rst_next_op got %0d want 6 (timeout %0d)", zr, to); end
    endtask

    task automatic test_random();
        localparam int N = 10000;
        logic [31:0] exp_q[$], expu_q[$];
        logic [31:0] hold_z, e, eu;
        bit          hold = 0, acc;
        int          issued = 0, got = 0, cyc = 0;
        a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        while ((issued < N || exp_q.size() != 0) && cyc < 90000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (issued >= N) in_valid = 1'b0;
            if (out_valid && hold) begin
                n_chk++; if (z !== hold_z) begin n_fail++; $display("FAIL rnd_stall_z got %h want %h", z, hold_z); end
            end
            n_chk++; if (u_out_valid !== out_valid) begin n_fail++; $display("FAIL rnd_u_valid got %b want %b", u_out_valid, out_valid); end
            acc = in_valid && in_ready;
            if (acc) begin
                exp_q.push_back(model_mul(a, b, is_signed));
                expu_q.push_back(model_mul(a, b, 1'b0));
            end
            if (out_valid && out_ready) begin
                got++;
                n_chk++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra_result got %h want none", z); end
                else begin
                    e = exp_q.pop_front(); eu = expu_q.pop_front();
                    if (z !== e) begin n_fail++; $display("FAIL rnd_z got %h want %h", z, e); end
                    n_chk++; if (u_z !== eu) begin n_fail++; $display("FAIL rnd_u_z got %h want %h", u_z, eu); end
                end
            end
            hold = out_valid && !out_ready;
            hold_z = z;
            tick();
            cyc++;
            if (acc) begin
                issued++;
                a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_chk++; if (cyc >= 90000) begin n_fail++; $display("FAIL rnd_timeout got %0d cycles", cyc); end
        n_chk++; if (got !== N) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_ignore_busy();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wallace_mul16_seq.md
Name: wallace_mul16_seq

Overview:
Multi-cycle 16x16 multiplier controller built around one instance of the team's wallace_8x8_product block. It accepts an operand pair over a valid/ready handshake and splits both operands into bytes. It then sequences the four byte-by-byte partial products through the shared 8x8 Wallace unit, accumulating them into a 32-bit result, and returns the result over a valid/ready handshake. Optional two's-complement mode uses sign-magnitude conversion around the unsigned array. It sits in the ALU/multiply path wherever a full 16x16 array is too costly.

Parameters:
SIGNED_EN, 1, 1 = honour the is_signed input; 0 = is_signed ignored, always unsigned

Ports:
clk  input  1  clock, all state on rising edge
clrn  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
a  input  16  multiplicand
b  input  16  multiplier
is_signed  input  1  treat a, b as two's complement (sampled with operands)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
z  output  32  product
busy  output  1  high in MUL or DONE

Behaviour:
- Clock and reset: one clock clk. Reset clrn is asynchronous and active-low. Every register clears immediately on clrn low, independent of clk.
- Reset values:
  - state = IDLE, step = 0, acc = 0, z = 0
  - out_valid = 0, busy = 0, in_ready = 1 (decoded from state)
- Operand registers: ma, mb (16 bit), neg (1 bit).
- State machine:
  - IDLE:
    - in_ready = 1.
    - On in_valid & in_ready, capture operands and go to MUL with step = 0 and acc = 0.
    - Operand capture, signed case (SIGNED_EN & is_signed): ma = |a|, mb = |b| as 16-bit unsigned magnitudes (0x8000 -> 0x8000), neg = a[15] ^ b[15].
    - Operand capture, otherwise: ma = a, mb = b, neg = 0.
  - MUL:
    - in_ready = 0. One partial product per cycle; step runs 0..3.
    - Operand byte selected by step: ia = step[0], ib = step[1].
    - Multiplier inputs: ma[8*ia +: 8] and mb[8*ib +: 8].
    - Accumulate: acc <= acc + (p16 << 8*(ia+ib)), where p16 is the 16-bit product from the 8x8 unit. 32-bit add; no overflow is possible.
    - After step 3 is accumulated, go to DONE.
    - On that same edge: z <= neg ? (~acc_next + 1) : acc_next, and out_valid <= 1.
  - DONE:
    - out_valid = 1, in_ready = 0.
    - z is held stable until out_ready.
    - On out_valid & out_ready, go to IDLE and clear out_valid.
    - A new operand cannot be accepted on the same edge; the earliest accept is the next cycle.
- Latency: with accept at edge T, MUL occupies edges T+1..T+4 and out_valid is high after edge T+4. Minimum issue interval is 6 cycles.
- The 8x8 unit is purely combinational between the registers. Its inputs are don't-care outside MUL; drive them from ma/mb bytes anyway, with no gating.
- Boundary conditions:
  - in_valid while MUL/DONE: ignored; the operands are not captured.
  - a, b, is_signed changing after accept: no effect.
  - out_ready high before out_valid: no effect.
  - clrn low mid-MUL or in DONE: the operation is aborted, state returns to IDLE and the reset values apply. No result is ever produced for the aborted operands.
  - Signed extreme: 0x8000 * 0x8000 = 0x40000000. Zero result with neg = 1 yields 0.
- busy = (state != IDLE).

Test Plan:
- Unsigned: a=0xFFFF, b=0xFFFF, is_signed=0, out_ready=1 -> out_valid rises exactly 4 edges after the accept edge, z=0xFFFE0001, busy high for 5 cycles.
- Signed: pairs (0x8000,0x8000)->0x40000000, (0xFFFF,0x0002)->0xFFFFFFFE, (0x7FFF,0x8000)->0xC0008000, (0x0000,0x8000)->0x00000000. With SIGNED_EN=0, (0xFFFF,0x0002) -> 0x0001FFFE.
- Backpressure: complete a=0x1234, b=0x5678 with out_ready=0 for 10 cycles -> z=0x06260060 stable, out_valid=1, in_ready=0 throughout. Raise out_ready -> IDLE next edge, in_ready=1.
- Ignore during busy: accept (3,5), then assert in_valid with (7,9) during MUL -> z=15. (7,9) is not taken until in_ready returns.
- Reset mid-op: accept (0x00FF,0x0100), drop clrn asynchronously after the second MUL edge -> out_valid=0, z=0, in_ready=1 immediately. Next op (2,3) -> z=6.
- Random: 10,000 random a, b, is_signed with random out_ready stalls, compared against a behavioural 16x16 multiply -> zero mismatches. Handshake checker: no lost or duplicated results.
